// File: rtl/rr_mux.sv
// N-channel valid/ready multiplexer with a single registered output stage.
// Arbitration is round-robin (RR=1) or fixed priority, channel 0 highest (RR=0).
`ifndef WORD
`define WORD 64
`endif

module rr_mux #(
  parameter int WIDTH = `WORD,
  parameter int N     = 4,
  parameter bit RR    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_sel
);

  localparam int SW = $clog2(N);

  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [SW-1:0]    grant_idx_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             grant_any_s;
  logic             stage_free_s;
  logic             in_xfer_s;

  // Arbiter: first valid channel searching upward from ptr (RR) or from 0 (fixed).
  always_comb begin : arb
    int          cand;
    logic [SW-1:0] cand_idx;
    cand         = 0;
    cand_idx     = '0;
    grant_any_s  = 1'b0;
    grant_idx_s  = '0;
    grant_data_s = '0;
    for (int k = 0; k < N; k++) begin
      if (RR) begin
        cand = int'(ptr_q) + k;
        if (cand >= N) begin
          cand = cand - N;
        end else begin
          cand = cand;
        end
      end else begin
        cand = k;
      end
      cand_idx = SW'(cand);
      if (!grant_any_s && in_valid[cand_idx]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_idx;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == grant_idx_s) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Handshake decode and next-state for the output stage and round-robin pointer.
  always_comb begin
    stage_free_s = !valid_q || out_ready;
    in_xfer_s    = grant_any_s && stage_free_s && !reset;
    in_ready     = '0;
    valid_d      = valid_q;
    data_d       = data_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (in_xfer_s && (SW'(i) == grant_idx_s)) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
    if (in_xfer_s) begin
      valid_d = 1'b1;
      data_d  = grant_data_s;
      sel_d   = grant_idx_s;
      if (RR) begin
        ptr_d = (grant_idx_s == SW'(N-1)) ? '0 : grant_idx_s + SW'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_ready) begin
      // Output drained with nothing new arriving: data and index are kept.
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: three instances (RR N=4 W=64, fixed-priority N=4 W=64, RR N=2 W=5)
// checked with a vector table, hand sequences and an output scoreboard.
module tb_rr_mux;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset0, reset1, reset2;
  logic [255:0] in_data0, in_data1;
  logic [9:0]   in_data2;
  logic [3:0]   in_valid0, in_valid1, in_ready0, in_ready1;
  logic [1:0]   in_valid2, in_ready2;
  logic [63:0]  out_data0, out_data1;
  logic [4:0]   out_data2;
  logic         out_valid0, out_valid1, out_valid2;
  logic         out_ready0, out_ready1, out_ready2;
  logic [1:0]   out_sel0, out_sel1;
  logic [0:0]   out_sel2;

  rr_mux #(.WIDTH(64), .N(4), .RR(1'b1)) u0 (
    .clk(clk), .reset(reset0), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .out_sel(out_sel0));

  rr_mux #(.WIDTH(64), .N(4), .RR(1'b0)) u1 (
    .clk(clk), .reset(reset1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sel(out_sel1));

  rr_mux #(.WIDTH(5), .N(2), .RR(1'b1)) u2 (
    .clk(clk), .reset(reset2), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_sel(out_sel2));

  typedef struct {
    logic [63:0] d;
    logic [63:0] s;
  } sb_t;

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
  } vec_t;

  sb_t  sbq[$];
  logic m_ov;
  int   checks;
  int   errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle on instance dut: drive, check handshake and scoreboard, advance model.
  task automatic cycle(input int dut, input logic rst, input logic [3:0] v,
                       input logic ordy, input logic [3:0] exp_rdy);
    logic [3:0]  a_rdy;
    logic        a_ov;
    logic [63:0] a_d, a_s;
    sb_t         e;
    int          idx;
    case (dut)
      0: begin reset0 = rst; in_valid0 = v; out_ready0 = ordy; end
      1: begin reset1 = rst; in_valid1 = v; out_ready1 = ordy; end
      default: begin reset2 = rst; in_valid2 = v[1:0]; out_ready2 = ordy; end
    endcase
    @(negedge clk);
    case (dut)
      0: begin a_rdy = in_ready0; a_ov = out_valid0; a_d = out_data0; a_s = {62'd0, out_sel0}; end
      1: begin a_rdy = in_ready1; a_ov = out_valid1; a_d = out_data1; a_s = {62'd0, out_sel1}; end
      default: begin
        a_rdy = {2'b00, in_ready2}; a_ov = out_valid2;
        a_d = {59'd0, out_data2}; a_s = {63'd0, out_sel2};
      end
    endcase
    chk($sformatf("in_ready u%0d", dut), {60'd0, a_rdy}, {60'd0, exp_rdy});
    chk($sformatf("out_valid u%0d", dut), {63'd0, a_ov}, {63'd0, m_ov});
    if (m_ov) begin
      if (sbq.size() == 0) begin
        chk($sformatf("sb_underflow u%0d", dut), 64'd0, 64'd1);
      end else begin
        e = sbq[0];
        chk($sformatf("out_data u%0d", dut), a_d, e.d);
        chk($sformatf("out_sel u%0d", dut), a_s, e.s);
        if (ordy && !rst) void'(sbq.pop_front());
      end
    end
    if (rst) begin
      sbq.delete();
      m_ov = 1'b0;
    end else begin
      m_ov = (exp_rdy != 4'd0) || (m_ov && !ordy);
      if (exp_rdy != 4'd0) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (exp_rdy[i]) idx = i;
        case (dut)
          0: e.d = in_data0[idx*64 +: 64];
          1: e.d = in_data1[idx*64 +: 64];
          default: e.d = {59'd0, in_data2[idx*5 +: 5]};
        endcase
        e.s = 64'(idx);
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    checks = 0;
    errors = 0;
    m_ov   = 1'b0;

    // Round-robin sweep, idle, then sparse valid with wrap from ptr=3.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000};
    tbl[7]  = '{4'b0100, 1'b1, 4'b0100};
    tbl[8]  = '{4'b0010, 1'b1, 4'b0010};
    tbl[9]  = '{4'b0001, 1'b1, 4'b0001};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000};

    for (int i = 0; i < 4; i++) in_data0[i*64 +: 64] = 64'(10 + i);
    in_data1[0*64 +: 64] = 64'd100;
    in_data1[1*64 +: 64] = -64'sd350;
    in_data1[2*64 +: 64] = 64'd200;
    in_data1[3*64 +: 64] = 64'd300;
    in_data2 = {5'd11, 5'd22};

    reset0 = 1'b1; reset1 = 1'b1; reset2 = 1'b1;
    in_valid0 = 4'b1111; in_valid1 = 4'b0000; in_valid2 = 2'b00;
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with every channel requesting.
    for (int r = 0; r < 2; r++) begin
      cycle(0, 1'b1, 4'b1111, 1'b1, 4'b0000);
      chk("rst out_data u0", out_data0, 64'd0);
      chk("rst out_sel u0", {62'd0, out_sel0}, 64'd0);
      chk("rst out_valid u0", {63'd0, out_valid0}, 64'd0);
    end
    reset1 = 1'b0;
    reset2 = 1'b0;

    for (int i = 0; i < 11; i++) cycle(0, 1'b0, tbl[i].v, tbl[i].ordy, tbl[i].rdy);

    // Back-pressure on a ch2 word of 5, stall with valid dropping, then ch3 next.
    in_data0[2*64 +: 64] = 64'd5;
    cycle(0, 1'b0, 4'b0100, 1'b1, 4'b0100);
    cycle(0, 1'b0, 4'b1111, 1'b0, 4'b0000);
    cycle(0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    cycle(0, 1'b0, 4'b1111, 1'b0, 4'b0000);
    chk("bp held data u0", out_data0, 64'd5);
    cycle(0, 1'b0, 4'b1111, 1'b1, 4'b1000);
    cycle(0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    cycle(0, 1'b0, 4'b0000, 1'b1, 4'b0000);

    // Fixed priority: lowest valid index wins, never rotates.
    cycle(1, 1'b0, 4'b1111, 1'b1, 4'b0001);
    cycle(1, 1'b0, 4'b1110, 1'b1, 4'b0010);
    cycle(1, 1'b0, 4'b1010, 1'b1, 4'b0010);
    chk("neg data u1", out_data1, 64'hFFFF_FFFF_FFFF_FEA2);
    cycle(1, 1'b0, 4'b1010, 1'b1, 4'b0010);
    cycle(1, 1'b0, 4'b1111, 1'b1, 4'b0001);
    cycle(1, 1'b0, 4'b0000, 1'b1, 4'b0000);
    cycle(1, 1'b0, 4'b0000, 1'b1, 4'b0000);

    // Narrow instance: reset while holding a word, pointer returns to 0.
    cycle(2, 1'b0, 4'b0011, 1'b1, 4'b0001);
    cycle(2, 1'b0, 4'b0011, 1'b0, 4'b0000);
    cycle(2, 1'b1, 4'b0011, 1'b0, 4'b0000);
    cycle(2, 1'b1, 4'b0011, 1'b1, 4'b0000);
    cycle(2, 1'b0, 4'b0011, 1'b1, 4'b0001);
    cycle(2, 1'b0, 4'b0011, 1'b1, 4'b0010);
    cycle(2, 1'b0, 4'b0000, 1'b1, 4'b0000);
    cycle(2, 1'b0, 4'b0000, 1'b1, 4'b0000);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
